// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// sdram_arb_pkg : shared types for the SDRAM port arbiter.   rev 1.0
// ------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int ADDR_MAX    = 32;
  localparam int TIMEOUT_DEF = 64;
  localparam int TO_CNT_W    = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Address is stored at the widest supported size and trimmed on issue.
  typedef struct packed {
    logic                we;
    logic [ADDR_MAX-1:0] addr;
    logic [15:0]         wdata;
    logic [1:0]          wm;
  } slot_t;

  function automatic int to_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// sdram_req_if / sdram_down_if : requester-side and controller-side buses.   rev 1.0
// ------------------------------------------------------------------------
interface sdram_req_if #(
  parameter int N_PORTS   = 3,
  parameter int ADDR_BITS = 22
) ();
  logic [N_PORTS-1:0]                port_req;
  logic [N_PORTS-1:0]                port_we;
  logic [N_PORTS-1:0][ADDR_BITS-1:0] port_addr;
  logic [N_PORTS-1:0][15:0]          port_wdata;
  logic [N_PORTS-1:0][1:0]           port_wm;
  logic [N_PORTS-1:0]                port_ack;
  logic [N_PORTS-1:0][15:0]          port_rdata;

  modport master (output port_req, port_we, port_addr, port_wdata, port_wm,
                  input  port_ack, port_rdata);
  modport slave  (input  port_req, port_we, port_addr, port_wdata, port_wm,
                  output port_ack, port_rdata);
endinterface

interface sdram_down_if #(
  parameter int ADDR_BITS = 22
) ();
  logic                 down_req;
  logic                 down_we;
  logic [ADDR_BITS-1:0] down_address;
  logic [15:0]          down_data_write;
  logic [1:0]           down_wm;
  logic                 down_ack;
  logic [15:0]          down_data_read;

  modport master (output down_req, down_we, down_address, down_data_write, down_wm,
                  input  down_ack, down_data_read);
  modport slave  (input  down_req, down_we, down_address, down_data_write, down_wm,
                  output down_ack, down_data_read);
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter_rr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first request at or after rr.   rev 1.0
// ------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_PORTS = 3,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   rr,
  output logic [N_PORTS-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      j = (int'(rr) + i) % N_PORTS;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// sdram_arbiter : serialises N requesters onto one SDRAM controller port.   rev 1.0
// ------------------------------------------------------------------------
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_PORTS   = 3,
  parameter int ADDR_BITS = 22,
  parameter int TIMEOUT   = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  sdram_req_if.slave   up,
  sdram_down_if.master down,
  output logic         timeout_err
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam int CNT_W = to_cnt_w(TIMEOUT);

  state_t             state, state_nx;
  slot_t              slot [N_PORTS];
  logic [N_PORTS-1:0] valid;
  logic [N_PORTS-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx, rr, owner;
  logic               win_any, grant, ack_seen, expire;
  logic [CNT_W-1:0]   cnt;

  rr_arbiter #(.N_PORTS(N_PORTS), .IDX_W(IDX_W)) u_rr (
    .req   (valid),
    .rr    (rr),
    .grant (win_oh),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    ack_seen = 1'b0;
    expire   = 1'b0;
    unique case (state)
      IDLE: if (win_any) begin
        grant    = 1'b1;
        state_nx = WAIT;
      end
      WAIT: if (down.down_ack) begin
        ack_seen = 1'b1;
        state_nx = DONE;
      end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
        expire   = 1'b1;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A new request takes priority over the grant clear so a same-cycle req is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      for (int p = 0; p < N_PORTS; p++) slot[p] <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (up.port_req[p]) begin
          valid[p]      <= 1'b1;
          slot[p].we    <= up.port_we[p];
          slot[p].addr  <= ADDR_MAX'(up.port_addr[p]);
          slot[p].wdata <= up.port_wdata[p];
          slot[p].wm    <= up.port_wm[p];
        end else if (grant && win_oh[p]) begin
          valid[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      rr                   <= '0;
      owner                <= '0;
      cnt                  <= '0;
      down.down_req        <= 1'b0;
      down.down_we         <= 1'b0;
      down.down_address    <= '0;
      down.down_data_write <= '0;
      down.down_wm         <= '0;
      up.port_rdata        <= '0;
      timeout_err          <= 1'b0;
    end else begin
      state         <= state_nx;
      down.down_req <= grant;
      if (grant) begin
        down.down_we         <= slot[win_idx].we;
        down.down_address    <= slot[win_idx].addr[ADDR_BITS-1:0];
        down.down_data_write <= slot[win_idx].wdata;
        down.down_wm         <= slot[win_idx].wm;
        owner                <= win_idx;
        rr                   <= (win_idx == IDX_W'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;
        cnt                  <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      for (int p = 0; p < N_PORTS; p++) begin
        if (ack_seen && !down.down_we && owner == IDX_W'(p))
          up.port_rdata[p] <= down.down_data_read;
      end
      if (expire) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    up.port_ack = '0;
    for (int p = 0; p < N_PORTS; p++)
      up.port_ack[p] = (state == DONE) && (owner == IDX_W'(p));
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_sdram_arbiter : directed self-checking bench for sdram_arbiter.   rev 1.0
// ------------------------------------------------------------------------
module tb_sdram_arbiter;

  localparam int N_PORTS   = 3;
  localparam int ADDR_BITS = 22;
  localparam int TIMEOUT   = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic timeout_err;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sdram_req_if  #(.N_PORTS(N_PORTS), .ADDR_BITS(ADDR_BITS)) up ();
  sdram_down_if #(.ADDR_BITS(ADDR_BITS)) dn ();

  sdram_arbiter #(.N_PORTS(N_PORTS), .ADDR_BITS(ADDR_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .up          (up.slave),
    .down        (dn.master),
    .timeout_err (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [21:0] addr,
                          input logic [15:0] wdata, input logic [1:0] wm);
    up.port_req[p]   = 1'b1;
    up.port_we[p]    = we;
    up.port_addr[p]  = addr;
    up.port_wdata[p] = wdata;
    up.port_wm[p]    = wm;
  endtask

  task automatic release_req();
    tick();
    up.port_req = '0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!dn.down_req && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_req"}, 32'(dn.down_req), 32'd1);
  endtask

  task automatic ack_now(input string tag, input int p, input logic [15:0] rd);
    dn.down_ack       = 1'b1;
    dn.down_data_read = rd;
    tick();
    dn.down_ack = 1'b0;
    check_eq({tag, "_ack"}, 32'(up.port_ack), 32'(1 << p));
  endtask

  task automatic serve(input string tag, input int p, input logic [21:0] addr,
                       input logic we, input logic [15:0] rd);
    wait_req(tag);
    check_eq({tag, "_addr"}, 32'(dn.down_address), 32'(addr));
    check_eq({tag, "_we"}, 32'(dn.down_we), 32'(we));
    ack_now(tag, p, rd);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_down_req"}, 32'(dn.down_req), 32'd0);
    check_eq({tag, "_down_we"}, 32'(dn.down_we), 32'd0);
    check_eq({tag, "_down_addr"}, 32'(dn.down_address), 32'd0);
    check_eq({tag, "_down_wdata"}, 32'(dn.down_data_write), 32'd0);
    check_eq({tag, "_down_wm"}, 32'(dn.down_wm), 32'd0);
    check_eq({tag, "_port_ack"}, 32'(up.port_ack), 32'd0);
    check_eq({tag, "_rdata_any"}, 32'(|up.port_rdata), 32'd0);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic count_idle(input string tag, input int cycles);
    int act = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (dn.down_req || (|up.port_ack)) act++;
    end
    check_eq({tag, "_quiet"}, 32'(act), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n             = 1'b0;
    up.port_req       = '0;
    up.port_we        = '0;
    up.port_addr      = '0;
    up.port_wdata     = '0;
    up.port_wm        = '0;
    dn.down_ack       = 1'b0;
    dn.down_data_read = '0;
    do_reset();
    check_reset_state("rst");

    // Single read on port 1, controller answers five cycles after down_req
    set_port(1, 1'b0, 22'h00123, 16'h0, 2'b00);
    release_req();
    check_eq("rd_n1_req", 32'(dn.down_req), 32'd0);
    tick();
    check_eq("rd_n2_req", 32'(dn.down_req), 32'd1);
    check_eq("rd_n2_addr", 32'(dn.down_address), 32'h00123);
    check_eq("rd_n2_we", 32'(dn.down_we), 32'd0);
    tick();
    check_eq("rd_n3_req", 32'(dn.down_req), 32'd0);
    repeat (3) tick();
    check_eq("rd_hold_addr", 32'(dn.down_address), 32'h00123);
    tick();
    ack_now("rd", 1, 16'hBEEF);
    check_eq("rd_rdata", 32'(up.port_rdata[1]), 32'hBEEF);
    tick();
    check_eq("rd_ack_drop", 32'(up.port_ack), 32'd0);
    check_eq("rd_rdata_hold", 32'(up.port_rdata[1]), 32'hBEEF);

    // Contention from rr=0, twice in a row
    do_reset();
    for (int p = 0; p < N_PORTS; p++) set_port(p, 1'b0, 22'(32'h100 + p), 16'h0, 2'b00);
    release_req();
    serve("c1p0", 0, 22'h100, 1'b0, 16'h1111);
    serve("c1p1", 1, 22'h101, 1'b0, 16'h2222);
    serve("c1p2", 2, 22'h102, 1'b0, 16'h3333);
    check_eq("c1_rd0", 32'(up.port_rdata[0]), 32'h1111);
    check_eq("c1_rd1", 32'(up.port_rdata[1]), 32'h2222);
    check_eq("c1_rd2", 32'(up.port_rdata[2]), 32'h3333);
    tick();
    for (int p = 0; p < N_PORTS; p++) set_port(p, 1'b0, 22'(32'h200 + p), 16'h0, 2'b00);
    release_req();
    serve("c2p0", 0, 22'h200, 1'b0, 16'h4444);
    serve("c2p1", 1, 22'h201, 1'b0, 16'h5555);
    serve("c2p2", 2, 22'h202, 1'b0, 16'h6666);
    check_eq("c2_rd2", 32'(up.port_rdata[2]), 32'h6666);

    // Overwrite: port 2 rewritten while port 0 is in flight
    tick();
    set_port(0, 1'b0, 22'h300, 16'h0, 2'b00);
    release_req();
    set_port(2, 1'b0, 22'h010, 16'h0, 2'b00);
    release_req();
    check_eq("ow_p0_req", 32'(dn.down_req), 32'd1);
    set_port(2, 1'b0, 22'h020, 16'h0, 2'b00);
    release_req();
    check_eq("ow_p0_addr", 32'(dn.down_address), 32'h300);
    ack_now("ow_p0", 0, 16'h0AAA);
    serve("ow_p2", 2, 22'h020, 1'b0, 16'h0BBB);
    count_idle("ow", 10);
    check_eq("ow_rd0", 32'(up.port_rdata[0]), 32'h0AAA);
    check_eq("ow_rd2", 32'(up.port_rdata[2]), 32'h0BBB);

    // Masked write on port 0 at the top address
    set_port(0, 1'b1, 22'h3FFFFF, 16'hA5A5, 2'b10);
    release_req();
    wait_req("wr");
    check_eq("wr_addr", 32'(dn.down_address), 32'h3FFFFF);
    check_eq("wr_we", 32'(dn.down_we), 32'd1);
    check_eq("wr_wdata", 32'(dn.down_data_write), 32'hA5A5);
    check_eq("wr_wm", 32'(dn.down_wm), 32'd2);
    ack_now("wr", 0, 16'hDEAD);
    check_eq("wr_rdata0", 32'(up.port_rdata[0]), 32'h0AAA);

    // Timeout on port 1 with port 2 queued behind it (rr=1 after the write)
    tick();
    set_port(1, 1'b0, 22'h055, 16'h0, 2'b00);
    set_port(2, 1'b0, 22'h066, 16'h0, 2'b00);
    release_req();
    wait_req("to");
    check_eq("to_addr", 32'(dn.down_address), 32'h055);
    n = 0;
    while (up.port_ack == '0 && n < TIMEOUT + 10) begin
      tick();
      n++;
    end
    check_eq("to_cycles", 32'(n), 32'(TIMEOUT));
    check_eq("to_ack", 32'(up.port_ack), 32'b010);
    check_eq("to_err", 32'(timeout_err), 32'd1);
    check_eq("to_rdata1", 32'(up.port_rdata[1]), 32'h5555);
    dn.down_ack       = 1'b1;
    dn.down_data_read = 16'hCAFE;
    tick();
    dn.down_ack = 1'b0;
    check_eq("to_late_ack", 32'(up.port_ack), 32'd0);
    serve("to_next", 2, 22'h066, 1'b0, 16'h7777);
    check_eq("to_rdata2", 32'(up.port_rdata[2]), 32'h7777);
    check_eq("to_rdata1_keep", 32'(up.port_rdata[1]), 32'h5555);
    check_eq("to_err_sticky", 32'(timeout_err), 32'd1);

    // Reset while waiting on the controller, with port 1 still pending
    tick();
    set_port(0, 1'b0, 22'h077, 16'h0, 2'b00);
    set_port(1, 1'b0, 22'h088, 16'h0, 2'b00);
    release_req();
    wait_req("rw");
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("rw");
    dn.down_ack       = 1'b1;
    dn.down_data_read = 16'h1234;
    tick();
    dn.down_ack = 1'b0;
    check_eq("rw_late_ack", 32'(up.port_ack), 32'd0);
    check_eq("rw_rdata0", 32'(up.port_rdata[0]), 32'd0);
    count_idle("rw", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between N_PORTS independent requesters (PRG ROM, CHR RAM, MCU loader).
- Each requester issues single-cycle request pulses of the same kind the CHR RAM front-end produces.
- Requests are latched per port, serialised round-robin to the controller, and completed with a per-port ack and a held read word.
- Sits between the per-bus front-ends and the SDRAM controller, all in the SDRAM clock domain.

Parameters:
- N_PORTS, 3, number of requesters; legal range 2..4.
- ADDR_BITS, 22, SDRAM word address width.
- TIMEOUT, 64, maximum cycles to wait for down_ack before abandoning a transaction.

Ports:
- clk  in  1  SDRAM clock.
- rst_n  in  1  synchronous active-low reset.
- port_req  in  N_PORTS  per-port single-cycle request pulse.
- port_we  in  N_PORTS  per-port write flag, sampled with req.
- port_addr  in  N_PORTS x ADDR_BITS  word address, sampled with req.
- port_wdata  in  N_PORTS x 16  write data, sampled with req.
- port_wm  in  N_PORTS x 2  byte write mask, 1 = byte masked, sampled with req.
- port_ack  out  N_PORTS  one-cycle pulse when the port's transaction completes.
- port_rdata  out  N_PORTS x 16  last read word per port, held until that port's next read ack.
- down_req  out  1  single-cycle request pulse to the controller.
- down_we, down_address[ADDR_BITS], down_data_write[16], down_wm[2]  out  command fields, stable from down_req until down_ack.
- down_ack  in  1  controller completion pulse; down_data_read is valid in the same cycle.
- down_data_read  in  16  controller read data.
- timeout_err  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All pending slots cleared; FSM goes to IDLE; rr pointer = 0.
  - down_req=0, down_we=0, down_address=0, down_data_write=0, down_wm=0.
  - port_ack=0, port_rdata=0, timeout_err=0.
  - A reset during WAIT abandons the transaction silently; a late down_ack after reset is ignored.
- Pending slot per port: {valid, we, addr, wdata, wm}.
  - port_req sets valid and captures the command fields.
  - A req arriving while that port's slot is valid and not yet issued overwrites the slot (latest wins).
  - A req arriving while that port is in flight fills the slot for a later turn.
- Arbitration: round-robin starting at rr; the first valid slot at or after rr wins. After a grant, rr = winner+1 mod N_PORTS.
- FSM states and transitions:
  - IDLE: if any slot is valid, register the winner's fields onto down_*, pulse down_req for one cycle, clear the winner's valid, record the owner, go to WAIT. Otherwise stay in IDLE.
  - WAIT: a cycle counter increments each cycle.
  - WAIT -> DONE: on down_ack. For a read, the owner's port_rdata latches down_data_read.
  - WAIT -> DONE on timeout: if the counter reaches TIMEOUT, set timeout_err and go to DONE without updating rdata.
  - DONE: pulse port_ack[owner] for one cycle, then return to IDLE.
- Latency, uncontended read: req at cycle N -> down_req at N+2 -> down_ack at cycle M -> port_ack and port_rdata valid at M+1 -> next grant possible at M+2.
- Writes follow the same timing; port_rdata is unchanged on a write.
- A req on the owner port in the same cycle as down_ack is captured into that port's slot, not lost.
- down_ack outside WAIT is ignored.
- Only one transaction is ever outstanding to the controller.

Decomposition:
- Package sdram_arb_pkg:
  - state enum (IDLE, WAIT, DONE);
  - typedef slot_t {we, addr, wdata, wm};
  - localparam width of the timeout counter, clog2(TIMEOUT+1).
- One natural sub-module: rr_arbiter (N_PORTS request vector plus rr pointer in, one-hot grant and index out; combinational).

Test Plan:
- Single read: port1 read, addr=0x00123 -> down_req at +2 cycles with down_address=0x00123, down_we=0. Controller acks 5 cycles later with 0xBEEF -> port_ack[1] for one cycle and port_rdata[1]=0xBEEF, held thereafter.
- Contention: ports 0, 1 and 2 pulse req in the same cycle, rr=0 -> grants in order 0, 1, 2. Next simultaneous burst starts at port 0 again, since rr has wrapped after port 2.
- Overwrite: port2 pulses req addr=0x10, then addr=0x20 while port0 is in flight -> exactly one port2 transaction, with addr=0x20.
- Write mask: port0 write, addr=0x3FFFFF, wdata=0xA5A5, wm=2'b10 -> down fields match exactly, port_ack[0] pulses, port_rdata[0] unchanged.
- Timeout: no down_ack for TIMEOUT cycles -> timeout_err=1, port_ack[owner] pulses, FSM back in IDLE, next pending request served; a late down_ack is ignored.
- Reset in WAIT: rst_n low for one cycle mid-transaction -> all outputs at reset values, no port_ack, pending requests dropped, a subsequent down_ack is ignored.
